// File: rtl/ac97_link_framer.sv
// AC'97 serial link framer.
// Generates the frame counter and SYNC, serialises one outgoing frame per
// frame period (tag slot followed by NSLOTS data slots, MSB first) and
// deserialises the incoming frame, handing it to the host as a parallel
// snapshot with a pending/ack/overrun handshake.
//
// Host handshake on the receive side: a capture sets in_pending and pulses
// in_frame_strobe; the host retires the frame by holding in_ack high for one
// cycle while in_pending is high. A capture that arrives while the previous
// frame is still pending and not being acked raises the sticky in_overrun
// (the new frame still overwrites the old one); in_overrun_clr clears it,
// with a simultaneous set taking priority.
module ac97_link_framer #(
    parameter int NSLOTS    = 12,
    parameter int SLOT_W    = 20,
    parameter int TAG_W     = 16,
    parameter int SYNC_BITS = 16
) (
    input  logic                     ac97_bitclk,
    input  logic                     rst,
    input  logic                     ac97_sdata_in,
    output logic                     ac97_sdata_out,
    output logic                     ac97_sync,
    input  logic [NSLOTS*SLOT_W-1:0] out_slots,
    input  logic [NSLOTS-1:0]        out_valid,
    output logic                     frame_start,
    output logic [NSLOTS*SLOT_W-1:0] in_slots,
    output logic [NSLOTS-1:0]        in_valid,
    output logic                     codec_ready,
    output logic                     in_frame_strobe,
    output logic                     in_pending,
    input  logic                     in_ack,
    output logic                     in_overrun,
    input  logic                     in_overrun_clr
);

    localparam int DATA_BITS  = NSLOTS * SLOT_W;
    localparam int FRAME_BITS = TAG_W + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 2);

    // Bit counter: names the bit currently on the bus.
    logic [CNT_W-1:0] bitcnt_q;
    logic [CNT_W-1:0] bitcnt_d;
    logic             last_bit;

    // Transmit path.
    logic [FRAME_BITS-1:0] tx_frame;
    logic [FRAME_BITS-1:0] tx_sr_q;
    logic                  sdata_out_q;
    logic                  sync_q;
    logic                  sync_d;

    // Receive path.
    logic [FRAME_BITS-1:0] rx_sr_q;
    logic                  armed_q;
    logic                  capture;
    logic [DATA_BITS-1:0]  in_slots_q;
    logic [NSLOTS-1:0]     in_valid_q;
    logic                  codec_ready_q;
    logic                  strobe_q;
    logic                  pending_q;
    logic                  overrun_q;

    // Next bit index, wrapping at the end of the frame.
    always_comb begin
        bitcnt_d = bitcnt_q + CNT_W'(1);
        if (bitcnt_q == CNT_LAST) begin
            bitcnt_d = '0;
        end
    end

    assign last_bit = (bitcnt_q == CNT_LAST);

    // SYNC is high for the last bit of a frame and the first SYNC_BITS-1 bits
    // of the next; decided from the index the bus will carry next period.
    always_comb begin
        sync_d = (bitcnt_d == CNT_LAST) || (bitcnt_d <= SYNC_LAST);
    end

    // Frame counter and SYNC flop.
    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            bitcnt_q <= CNT_LAST;
            sync_q   <= 1'b0;
        end else begin
            bitcnt_q <= bitcnt_d;
            sync_q   <= sync_d;
        end
    end

    // The host-facing strobe marks the period whose closing edge samples
    // out_slots/out_valid; it is forced low while reset is held.
    assign frame_start = last_bit & ~rst;

    // Assemble the outgoing frame: tag MSB set, slot valid bits, zero pad,
    // then each slot with invalid slots replaced by zeros.
    always_comb begin
        tx_frame                          = '0;
        tx_frame[FRAME_BITS-1]            = 1'b1;
        tx_frame[FRAME_BITS-2 -: NSLOTS]  = out_valid;
        for (int s = 0; s < NSLOTS; s++) begin
            if (out_valid[s]) begin
                tx_frame[s*SLOT_W +: SLOT_W] = out_slots[s*SLOT_W +: SLOT_W];
            end
        end
    end

    // Output shift register: the whole frame is captured at the frame
    // boundary so host changes afterwards cannot disturb the frame in flight.
    // The first bit goes straight to the output flop, the rest follow.
    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            tx_sr_q     <= '0;
            sdata_out_q <= 1'b0;
        end else if (last_bit) begin
            sdata_out_q <= tx_frame[FRAME_BITS-1];
            tx_sr_q     <= {tx_frame[FRAME_BITS-2:0], 1'b0};
        end else begin
            sdata_out_q <= tx_sr_q[FRAME_BITS-1];
            tx_sr_q     <= {tx_sr_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign ac97_sdata_out = sdata_out_q;
    assign ac97_sync      = sync_q;

    // Input shift register: the codec launches on the rising edge, so sample
    // mid-bit on the falling edge. After the last bit, bit 0 sits at the MSB.
    always_ff @(negedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            rx_sr_q <= '0;
        end else begin
            rx_sr_q <= {rx_sr_q[FRAME_BITS-2:0], ac97_sdata_in};
        end
    end

    // After reset the shift register holds no complete frame yet; armed_q
    // suppresses the capture on the first frame boundary after release.
    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    assign capture = last_bit & armed_q;

    // Atomic snapshot of the received frame at the frame boundary.
    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            in_slots_q    <= '0;
            in_valid_q    <= '0;
            codec_ready_q <= 1'b0;
        end else if (capture) begin
            in_slots_q    <= rx_sr_q[DATA_BITS-1:0];
            in_valid_q    <= rx_sr_q[FRAME_BITS-2 -: NSLOTS];
            codec_ready_q <= rx_sr_q[FRAME_BITS-1];
        end
    end

    // One-cycle strobe in the period following each capture.
    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= capture;
        end
    end

    // Pending flag: a capture always leaves a frame pending (an ack on the
    // same edge retires the previous frame); otherwise an ack clears it.
    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (capture) begin
            pending_q <= 1'b1;
        end else if (in_ack && pending_q) begin
            pending_q <= 1'b0;
        end
    end

    // Sticky overrun: an unacked pending frame was overwritten; set wins.
    always_ff @(posedge ac97_bitclk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (capture && pending_q && !in_ack) begin
            overrun_q <= 1'b1;
        end else if (in_overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign in_slots        = in_slots_q;
    assign in_valid        = in_valid_q;
    assign codec_ready     = codec_ready_q;
    assign in_frame_strobe = strobe_q;
    assign in_pending      = pending_q;
    assign in_overrun      = overrun_q;

endmodule
